// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit.
// Holds the FSM state encoding, opcode constants, datapath select encodings,
// the packed control word passed from the output decoder to the top, and the
// opcode -> immediate-format helper.
package multicycle_ctrl_pkg;

  // State encodings are visible on state_dbg, so the numeric values are fixed.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_ALU_WB  = 4'd7,
    S_EXEC_I  = 4'd8,
    S_JAL     = 4'd9,
    S_BEQ     = 4'd10,
    S_TRAP    = 4'd11
  } state_t;

  // Supported opcodes (instr[6:0]).
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // alu_op values understood by alu_ctrl.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

  // Immediate formats for the immediate generator.
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  // Writeback / PC result mux.
  localparam logic [1:0] RESULT_ALUOUT = 2'b00;
  localparam logic [1:0] RESULT_MEM    = 2'b01;
  localparam logic [1:0] RESULT_ALU    = 2'b10;

  // ALU operand A mux.
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  // ALU operand B mux.
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  // Memory address mux.
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  // Moore control word produced purely from the current state.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_en;
    logic       reg_write;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_word_t;

  // Immediate format from opcode; R-type and unknown opcodes fall back to 000.
  function automatic logic [2:0] imm_decode(input logic [6:0] op);
    logic [2:0] imm;
    imm = IMM_I;
    case (op)
      OP_LW, OP_I: imm = IMM_I;
      OP_SW:       imm = IMM_S;
      OP_BEQ:      imm = IMM_B;
      OP_JAL:      imm = IMM_J;
      default:     imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_out_decode.sv
// Combinational state -> control word decoder for multicycle_ctrl.
// Ports:
//   state  in   state_t      current FSM state
//   cw     out  ctrl_word_t  Moore control word for that state
// ir_write/pc_en are asserted unconditionally in FETCH and pc_en in BEQ; the
// top qualifies them with mem_ready and zero respectively.
module multicycle_ctrl_out_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_req    = 1'b1;
        cw.adr_src    = ADR_PC;
        cw.alu_src_a  = SRC_A_PC;
        cw.alu_src_b  = SRC_B_FOUR;
        cw.alu_op     = ALU_OP_ADD;
        cw.result_src = RESULT_ALU;
        cw.ir_write   = 1'b1;
        cw.pc_en      = 1'b1;
      end
      S_DECODE: begin
        // Branch target OldPC+imm is precomputed into ALUOut here.
        cw.alu_src_a = SRC_A_OLDPC;
        cw.alu_src_b = SRC_B_IMM;
        cw.alu_op    = ALU_OP_ADD;
      end
      S_MEM_ADR: begin
        cw.alu_src_a = SRC_A_RS1;
        cw.alu_src_b = SRC_B_IMM;
        cw.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        cw.mem_req = 1'b1;
        cw.adr_src = ADR_ALUOUT;
      end
      S_MEM_WB: begin
        cw.result_src = RESULT_MEM;
        cw.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        cw.mem_req = 1'b1;
        cw.mem_we  = 1'b1;
        cw.adr_src = ADR_ALUOUT;
      end
      S_EXEC_R: begin
        cw.alu_src_a = SRC_A_RS1;
        cw.alu_src_b = SRC_B_RS2;
        cw.alu_op    = ALU_OP_RTYPE;
      end
      S_ALU_WB: begin
        cw.result_src = RESULT_ALUOUT;
        cw.reg_write  = 1'b1;
      end
      S_EXEC_I: begin
        cw.alu_src_a = SRC_A_RS1;
        cw.alu_src_b = SRC_B_IMM;
        cw.alu_op    = ALU_OP_ITYPE;
      end
      S_JAL: begin
        // PC <= branch target from ALUOut while ALU forms OldPC+4 for rd.
        cw.alu_src_a  = SRC_A_OLDPC;
        cw.alu_src_b  = SRC_B_FOUR;
        cw.alu_op     = ALU_OP_ADD;
        cw.result_src = RESULT_ALUOUT;
        cw.pc_en      = 1'b1;
      end
      S_BEQ: begin
        cw.alu_src_a  = SRC_A_RS1;
        cw.alu_src_b  = SRC_B_RS2;
        cw.alu_op     = ALU_OP_SUB;
        cw.result_src = RESULT_ALUOUT;
        cw.pc_en      = 1'b1;
      end
      S_TRAP: begin
        cw.illegal = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback over one shared memory port
// and one ALU for lw, sw, R-ALU, I-ALU, beq and jal, and counts retired
// instructions.
// Parameters:
//   ILLEGAL_TRAP  1: unknown opcode enters TRAP until rst; 0: retires as NOP
//   CNT_W         width of the instret counter
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   opcode, zero, mem_ready  instruction opcode, ALU zero flag, memory done
//   mem_req, mem_we, adr_src memory request / write strobe / address select
//   ir_write, pc_en          IR+OldPC load, PC write enable
//   reg_write, result_src    register write enable, result mux
//   alu_src_a, alu_src_b     ALU operand muxes
//   alu_op, imm_src          ALU control class, immediate format
//   illegal                  high while trapped
//   instret                  retired instruction count
//   state_dbg                current state encoding
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int ILLEGAL_TRAP = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_en,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_dbg
);

  state_t     state;
  state_t     state_next;
  logic       retire;
  ctrl_word_t cw;
  ctrl_word_t ctrl;

  multicycle_ctrl_out_decode u_out_decode (
    .state (state),
    .cw    (cw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= state_next;
      if (retire) begin
        instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Next state plus the retire pulse that marks every transition back into
  // FETCH that completes an instruction.
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADR;
          OP_R:         state_next = S_EXEC_R;
          OP_I:         state_next = S_EXEC_I;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            if (ILLEGAL_TRAP != 0) begin
              state_next = S_TRAP;
            end else begin
              state_next = S_FETCH;
              retire     = 1'b1;
            end
          end
        endcase
      end
      S_MEM_ADR: state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_EXEC_R: state_next = S_ALU_WB;
      S_ALU_WB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_EXEC_I: state_next = S_ALU_WB;
      S_JAL:    state_next = S_ALU_WB;
      S_BEQ: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_FETCH;
    endcase
  end

  // FETCH only commits IR/PC once memory returns data; BEQ writes PC only
  // when taken. Reset blanks every control so an in-flight access is aborted.
  always_comb begin
    ctrl = cw;
    if (state == S_FETCH) begin
      ctrl.ir_write = cw.ir_write & mem_ready;
      ctrl.pc_en    = cw.pc_en & mem_ready;
    end
    if (state == S_BEQ) begin
      ctrl.pc_en = zero;
    end
    if (rst) begin
      ctrl = '0;
    end
  end

  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign adr_src    = ctrl.adr_src;
  assign ir_write   = ctrl.ir_write;
  assign pc_en      = ctrl.pc_en;
  assign reg_write  = ctrl.reg_write;
  assign result_src = ctrl.result_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign illegal    = ctrl.illegal;
  assign imm_src    = rst ? 3'b000 : imm_decode(opcode);
  assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl.
// A table of per-cycle {inputs, expected state, control word, instret} rows
// walks a trapping instance through R, lw (with waits), sw (with a fetch
// wait), beq taken/not taken, jal, I-type, reset during a store wait and an
// illegal opcode. A second instance (NOP mode, 4-bit counter) shares the
// inputs and is checked in hand-written sequences for NOP retirement and
// counter wrap.
module tb_multicycle_ctrl;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LW_OP = 7'b0000011;
  localparam logic [6:0] SW_OP = 7'b0100011;
  localparam logic [6:0] B_OP  = 7'b1100011;
  localparam logic [6:0] J_OP  = 7'b1101111;
  localparam logic [6:0] X_OP  = 7'b1111111;

  typedef struct {
    logic        rst;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic [3:0]  exp_state;
    logic [17:0] exp_ctrl;
    logic [31:0] exp_instret;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;

  logic        mem_req, mem_we, adr_src, ir_write, pc_en, reg_write, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0]  imm_src;
  logic [31:0] instret;
  logic [3:0]  state_dbg;

  logic        mem_req2, mem_we2, adr_src2, ir_write2, pc_en2, reg_write2, illegal2;
  logic [1:0]  result_src2, alu_src_a2, alu_src_b2, alu_op2;
  logic [2:0]  imm_src2;
  logic [3:0]  instret2;
  logic [3:0]  state_dbg2;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.ILLEGAL_TRAP(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
    .pc_en(pc_en), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .illegal(illegal), .instret(instret), .state_dbg(state_dbg)
  );

  multicycle_ctrl #(.ILLEGAL_TRAP(0), .CNT_W(4)) dut_nop (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req2), .mem_we(mem_we2), .adr_src(adr_src2), .ir_write(ir_write2),
    .pc_en(pc_en2), .reg_write(reg_write2), .result_src(result_src2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_op(alu_op2),
    .imm_src(imm_src2), .illegal(illegal2), .instret(instret2), .state_dbg(state_dbg2)
  );

  // Expected control word layout:
  // {mem_req, mem_we, adr_src, ir_write, pc_en, reg_write, illegal,
  //  result_src, alu_src_a, alu_src_b, alu_op, imm_src}
  function automatic logic [17:0] ctl(input logic mreq, input logic mwe, input logic adr,
                                      input logic irw, input logic pce, input logic rw,
                                      input logic ill, input logic [1:0] res,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] aop, input logic [2:0] imm);
    return {mreq, mwe, adr, irw, pce, rw, ill, res, a, b, aop, imm};
  endfunction

  function automatic logic [17:0] c_fetch(input logic go, input logic [2:0] imm);
    return ctl(1, 0, 0, go, go, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm);
  endfunction
  function automatic logic [17:0] c_dec(input logic [2:0] imm);
    return ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm);
  endfunction
  function automatic logic [17:0] c_madr(input logic [2:0] imm);
    return ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, imm);
  endfunction
  function automatic logic [17:0] c_mem(input logic we, input logic [2:0] imm);
    return ctl(1, we, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm);
  endfunction
  function automatic logic [17:0] c_wb(input logic [1:0] res, input logic [2:0] imm);
    return ctl(0, 0, 0, 0, 0, 1, 0, res, 2'b00, 2'b00, 2'b00, imm);
  endfunction
  function automatic logic [17:0] c_exec(input logic [1:0] b, input logic [1:0] aop,
                                         input logic [2:0] imm);
    return ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, b, aop, imm);
  endfunction
  function automatic logic [17:0] c_beq(input logic z, input logic [2:0] imm);
    return ctl(0, 0, 0, 0, z, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, imm);
  endfunction
  function automatic logic [17:0] c_jal(input logic [2:0] imm);
    return ctl(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, imm);
  endfunction
  function automatic logic [17:0] c_trap(input logic [2:0] imm);
    return ctl(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, imm);
  endfunction

  function automatic vec_t v(input logic r, input logic [6:0] op, input logic z,
                             input logic rdy, input logic [3:0] st,
                             input logic [17:0] c, input logic [31:0] cnt);
    vec_t t;
    t.rst = r; t.opcode = op; t.zero = z; t.mem_ready = rdy;
    t.exp_state = st; t.exp_ctrl = c; t.exp_instret = cnt;
    return t;
  endfunction

  // Drive inputs, let combinational outputs settle away from the clock edge.
  task automatic applyStimulus(input logic r, input logic [6:0] op, input logic z,
                               input logic rdy);
    rst = r; opcode = op; zero = z; mem_ready = rdy;
    #1;
  endtask

  // Advance one clock and land 1 time unit past the rising edge.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic runInstr(input logic [6:0] op, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      applyStimulus(1'b0, op, 1'b0, 1'b1);
      stepClock();
    end
  endtask

  initial begin
    // 1: R-type, zero-wait memory
    tbl.push_back(v(1, R_OP, 0, 1, 4'd0, 18'd0, 0));
    tbl.push_back(v(0, R_OP, 0, 1, 4'd0, c_fetch(1, 3'b000), 0));
    tbl.push_back(v(0, R_OP, 0, 1, 4'd1, c_dec(3'b000), 0));
    tbl.push_back(v(0, R_OP, 0, 1, 4'd6, c_exec(2'b00, 2'b10, 3'b000), 0));
    tbl.push_back(v(0, R_OP, 0, 1, 4'd7, c_wb(2'b00, 3'b000), 0));
    // 2: lw with three wait cycles in MEM_RD
    tbl.push_back(v(0, LW_OP, 0, 1, 4'd0, c_fetch(1, 3'b000), 1));
    tbl.push_back(v(0, LW_OP, 0, 1, 4'd1, c_dec(3'b000), 1));
    tbl.push_back(v(0, LW_OP, 0, 1, 4'd2, c_madr(3'b000), 1));
    tbl.push_back(v(0, LW_OP, 0, 0, 4'd3, c_mem(0, 3'b000), 1));
    tbl.push_back(v(0, LW_OP, 0, 0, 4'd3, c_mem(0, 3'b000), 1));
    tbl.push_back(v(0, LW_OP, 0, 0, 4'd3, c_mem(0, 3'b000), 1));
    tbl.push_back(v(0, LW_OP, 0, 1, 4'd3, c_mem(0, 3'b000), 1));
    tbl.push_back(v(0, LW_OP, 0, 1, 4'd4, c_wb(2'b01, 3'b000), 1));
    // sw with one fetch wait: ir_write/pc_en must stay low while waiting
    tbl.push_back(v(0, SW_OP, 0, 0, 4'd0, c_fetch(0, 3'b001), 2));
    tbl.push_back(v(0, SW_OP, 0, 1, 4'd0, c_fetch(1, 3'b001), 2));
    tbl.push_back(v(0, SW_OP, 0, 1, 4'd1, c_dec(3'b001), 2));
    tbl.push_back(v(0, SW_OP, 0, 1, 4'd2, c_madr(3'b001), 2));
    tbl.push_back(v(0, SW_OP, 0, 1, 4'd5, c_mem(1, 3'b001), 2));
    // 3: beq taken then not taken
    tbl.push_back(v(0, B_OP, 1, 1, 4'd0, c_fetch(1, 3'b010), 3));
    tbl.push_back(v(0, B_OP, 1, 1, 4'd1, c_dec(3'b010), 3));
    tbl.push_back(v(0, B_OP, 1, 1, 4'd10, c_beq(1, 3'b010), 3));
    tbl.push_back(v(0, B_OP, 0, 1, 4'd0, c_fetch(1, 3'b010), 4));
    tbl.push_back(v(0, B_OP, 0, 1, 4'd1, c_dec(3'b010), 4));
    tbl.push_back(v(0, B_OP, 0, 1, 4'd10, c_beq(0, 3'b010), 4));
    // 4: jal
    tbl.push_back(v(0, J_OP, 0, 1, 4'd0, c_fetch(1, 3'b011), 5));
    tbl.push_back(v(0, J_OP, 0, 1, 4'd1, c_dec(3'b011), 5));
    tbl.push_back(v(0, J_OP, 0, 1, 4'd9, c_jal(3'b011), 5));
    tbl.push_back(v(0, J_OP, 0, 1, 4'd7, c_wb(2'b00, 3'b011), 5));
    // I-type
    tbl.push_back(v(0, I_OP, 0, 1, 4'd0, c_fetch(1, 3'b000), 6));
    tbl.push_back(v(0, I_OP, 0, 1, 4'd1, c_dec(3'b000), 6));
    tbl.push_back(v(0, I_OP, 0, 1, 4'd8, c_exec(2'b01, 2'b11, 3'b000), 6));
    tbl.push_back(v(0, I_OP, 0, 1, 4'd7, c_wb(2'b00, 3'b000), 6));
    // 6: reset during a store wait blanks mem_req/mem_we that cycle
    tbl.push_back(v(0, SW_OP, 0, 1, 4'd0, c_fetch(1, 3'b001), 7));
    tbl.push_back(v(0, SW_OP, 0, 1, 4'd1, c_dec(3'b001), 7));
    tbl.push_back(v(0, SW_OP, 0, 1, 4'd2, c_madr(3'b001), 7));
    tbl.push_back(v(0, SW_OP, 0, 0, 4'd5, c_mem(1, 3'b001), 7));
    tbl.push_back(v(1, SW_OP, 0, 0, 4'd5, 18'd0, 7));
    // 5: illegal opcode traps, reset releases it
    tbl.push_back(v(0, X_OP, 0, 1, 4'd0, c_fetch(1, 3'b000), 0));
    tbl.push_back(v(0, X_OP, 0, 1, 4'd1, c_dec(3'b000), 0));
    tbl.push_back(v(0, X_OP, 0, 1, 4'd11, c_trap(3'b000), 0));
    tbl.push_back(v(0, X_OP, 0, 1, 4'd11, c_trap(3'b000), 0));
    tbl.push_back(v(1, X_OP, 0, 1, 4'd11, 18'd0, 0));
    tbl.push_back(v(0, R_OP, 0, 0, 4'd0, c_fetch(0, 3'b000), 0));

    $display("[TB] start, %0d table steps", tbl.size());
    applyStimulus(1'b1, R_OP, 1'b0, 1'b1);
    stepClock();

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].rst, tbl[i].opcode, tbl[i].zero, tbl[i].mem_ready);
      checkOutput("state", i, {28'd0, state_dbg}, {28'd0, tbl[i].exp_state});
      checkOutput("ctrl", i,
                  {14'd0, mem_req, mem_we, adr_src, ir_write, pc_en, reg_write, illegal,
                   result_src, alu_src_a, alu_src_b, alu_op, imm_src},
                  {14'd0, tbl[i].exp_ctrl});
      checkOutput("instret", i, instret, tbl[i].exp_instret);
      stepClock();
    end

    // NOP mode: unknown opcode retires in two cycles; trapping copy sits in TRAP.
    applyStimulus(1'b1, X_OP, 1'b0, 1'b1);
    stepClock();
    runInstr(X_OP, 2);
    applyStimulus(1'b0, X_OP, 1'b0, 1'b1);
    checkOutput("nop_state", 0, {28'd0, state_dbg2}, 32'd0);
    checkOutput("nop_instret", 0, {28'd0, instret2}, 32'd1);
    checkOutput("nop_illegal", 0, {31'd0, illegal2}, 32'd0);
    checkOutput("trap_state", 0, {28'd0, state_dbg}, 32'd11);
    checkOutput("trap_instret", 0, instret, 32'd0);

    // Counter wrap: 16 R-type retirements wrap a 4-bit counter to zero.
    applyStimulus(1'b1, R_OP, 1'b0, 1'b1);
    stepClock();
    for (int n = 1; n <= 16; n++) begin
      runInstr(R_OP, 4);
      if (n == 15) begin
        checkOutput("wrap_pre", n, {28'd0, instret2}, 32'd15);
      end
    end
    applyStimulus(1'b0, R_OP, 1'b0, 1'b1);
    checkOutput("wrap_zero", 16, {28'd0, instret2}, 32'd0);
    checkOutput("wide_count", 16, instret, 32'd16);
    checkOutput("wrap_state", 16, {28'd0, state_dbg2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
